// File: rtl/irq_priority_ctrl.sv
// irq_priority_ctrl
// Clocked interrupt priority controller. Requests are latched into sticky
// pending bits and qualified by the enable and block masks. One winner is
// picked by fixed or round-robin priority and presented to the consumer.
//
// Handshake: irq_valid/irq_id/irq_vec come from registered state only. While
// irq_valid is high, irq_id is held stable. A transfer happens on a rising
// edge where irq_valid and ack are both high. At that edge the winner's
// pending bit is cleared and the controller returns to IDLE. ack is ignored
// while irq_valid is low. If the presented channel stops being eligible before
// it is acked, the controller withdraws irq_valid without clearing anything.
module irq_priority_ctrl #(
   parameter int N_CH       = 9,
   parameter int ID_W       = $clog2(N_CH),
   parameter int RR_PTR_RST = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] req,
   input  logic [N_CH-1:0] en,
   input  logic [N_CH-1:0] blk,
   input  logic            mode,
   input  logic            ack,
   output logic            irq_valid,
   output logic [ID_W-1:0] irq_id,
   output logic [N_CH-1:0] irq_vec,
   output logic            irq_any,
   output logic [N_CH-1:0] pend
);

   typedef enum logic {
      IDLE  = 1'b0,
      VALID = 1'b1
   } state_t;

   // The FSM state is kept in a named register so checkers can bind to it.
   state_t          state;
   state_t          state_next;

   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] ptr_next;
   logic [ID_W-1:0] id_next;

   logic [N_CH-1:0] eligible;
   logic [N_CH-1:0] id_vec;
   logic [N_CH-1:0] clr;
   logic [N_CH-1:0] pend_next;
   logic            ack_take;

   logic            fix_found;
   logic [ID_W-1:0] fix_id;
   logic            rr_found;
   logic [ID_W-1:0] rr_id;
   logic [ID_W:0]   rr_sum;

   // A channel can be selected only if it is pending, enabled and not blocked.
   assign eligible = pend & en & ~blk;
   assign irq_any  = |eligible;

   // The presented interrupt and its one-hot form are decoded from registers only.
   assign id_vec    = {{(N_CH-1){1'b0}}, 1'b1} << irq_id;
   assign irq_valid = (state == VALID);
   assign irq_vec   = irq_valid ? id_vec : '0;

   // An accepted ack clears the winner. A new request on the same channel
   // re-pends it in the same edge. A disabled channel always drops its bit.
   assign ack_take  = irq_valid & ack;
   assign clr       = ack_take ? id_vec : '0;
   assign pend_next = ((pend & ~clr) | req) & en;

   // Fixed priority: the lowest eligible index wins.
   always_comb begin
      fix_found = 1'b0;
      fix_id    = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (!fix_found && eligible[i]) begin
            fix_found = 1'b1;
            fix_id    = ID_W'(i);
         end
      end
   end

   // Round-robin: the search starts at ptr and wraps from N_CH-1 to 0.
   // The sum ptr+i is always below 2*N_CH, so a single subtraction wraps it.
   always_comb begin
      rr_found = 1'b0;
      rr_id    = '0;
      rr_sum   = '0;
      for (int i = 0; i < N_CH; i++) begin
         rr_sum = {1'b0, ptr} + (ID_W+1)'(i);
         if (rr_sum >= (ID_W+1)'(N_CH)) begin
            rr_sum = rr_sum - (ID_W+1)'(N_CH);
         end
         if (!rr_found && eligible[rr_sum[ID_W-1:0]]) begin
            rr_found = 1'b1;
            rr_id    = rr_sum[ID_W-1:0];
         end
      end
   end

   // FSM next state, winner capture and round-robin pointer advance.
   always_comb begin
      state_next = state;
      id_next    = irq_id;
      ptr_next   = ptr;
      case (state)
         IDLE: begin
            if (irq_any) begin
               state_next = VALID;
               id_next    = mode ? rr_id : fix_id;
            end
         end
         VALID: begin
            if (ack) begin
               // ack takes priority over a withdrawal in the same cycle.
               state_next = IDLE;
               if (mode) begin
                  ptr_next = (irq_id == ID_W'(N_CH-1)) ? '0 : irq_id + ID_W'(1);
               end
            end else if (!eligible[irq_id]) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State, winner, pointer and pending registers. Reset overrides everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         irq_id <= '0;
         ptr    <= ID_W'(RR_PTR_RST);
         pend   <= '0;
      end else begin
         state  <= state_next;
         irq_id <= id_next;
         ptr    <= ptr_next;
         pend   <= pend_next;
      end
   end

endmodule

// File: doc/irq_priority_ctrl.md
Name: irq_priority_ctrl

Overview:
- Parametrised, clocked successor to the combinational 9-channel enable/block priority encoder.
- Latches interrupt requests into sticky per-channel pending bits and qualifies them with enable and block masks.
- Selects one winner by fixed or round-robin priority and presents it to the consumer under a valid/ack handshake.
- Sits between the raw request sources and the interrupt service logic; the default configuration is a drop-in for the 9-channel case.

Parameters:
- N_CH, 9: number of request channels, 2..32.
- ID_W, $clog2(N_CH): width of the winner index.
- RR_PTR_RST, 0: round-robin pointer value after reset, 0..N_CH-1.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N_CH  level request per channel.
- en  in  N_CH  channel enable; 0 blocks latching and clears that pending bit.
- blk  in  N_CH  block mask; 1 hides a pending channel from selection without clearing it.
- mode  in  1  0 = fixed priority (index 0 highest), 1 = round-robin.
- ack  in  1  consumer accepts the presented interrupt.
- irq_valid  out  1  winner presented.
- irq_id  out  ID_W  winner index, stable while irq_valid = 1.
- irq_vec  out  N_CH  one-hot of irq_id when irq_valid = 1, else 0.
- irq_any  out  1  OR of eligible = pend & en & ~blk (combinational from pend and current masks).
- pend  out  N_CH  pending register.

Behaviour:
- Reset (rst high at a clock edge): pend = 0, state IDLE, irq_valid = 0, irq_id = 0, irq_vec = 0, ptr = RR_PTR_RST. rst overrides all other inputs. Asserting rst mid-handshake drops irq_valid at that edge and discards the winner.
- Pending update, every edge: pend_next = ((pend & ~clr) | req) & en.
  - clr is one-hot of irq_id when ack is accepted, else 0.
  - req set wins over clr on the same channel, so the channel re-pends.
- Selection order:
  - Fixed: the lowest eligible index wins.
  - Round-robin: search starts at ptr and wraps from N_CH-1 to 0. The first eligible index wins.
- FSM, two states:
  - IDLE: irq_valid = 0. If eligible != 0, register the winner into irq_id and go to VALID.
  - VALID, ack = 1: clear pend[irq_id] and go to IDLE. If mode = 1, set ptr = (irq_id + 1) mod N_CH. If mode = 0, ptr is unchanged.
  - VALID, ack = 0 and eligible[irq_id] = 0 (en or blk changed): withdraw and go to IDLE. ptr and the remaining pend bits are unchanged.
  - VALID, otherwise: hold. irq_id must not change even if a higher-priority channel becomes eligible.
  - ack and withdrawal in the same cycle: ack has priority.
- Latency:
  - req high sampled at edge k: pend set at k, irq_valid high after edge k+1 (2 cycles, req to valid).
  - After an ack at edge m, the next winner can be valid after edge m+1. There is a 1-cycle minimum IDLE gap between grants.
- ack while IDLE: ignored, no state change.
- mode changes take effect at the next IDLE selection. ptr is retained across mode changes.
- All eligible bits zero in IDLE: stay IDLE, irq_any = 0.
- irq_vec and irq_valid are derived from registered state only, with no combinational path from req or ack.

Test Plan:
1. Reset, then req = 9'h000 for 5 cycles -> irq_valid = 0, pend = 0, irq_any = 0, irq_vec = 0 throughout.
2. Fixed mode, en = 9'h1FF, blk = 0, pulse req = 9'h014 for 1 cycle -> pend = 9'h014; irq_id = 2 valid 2 cycles after req. After ack, irq_id = 4 follows after a 1-cycle gap. After the second ack, pend = 0.
3. Round-robin, req held at 9'h103 (channels 0, 1, 8) with ack every valid cycle -> grant sequence 0, 1, 8, 0, 1, 8, including the wrap from 8 to 0.
4. blk = 9'h001 with pend[0] set -> channel 0 is not granted and pend[0] stays 1. Clearing blk -> channel 0 is granted 1 cycle later.
5. While VALID with irq_id = 3, drop en[3] -> irq_valid = 0 next cycle, pend[3] = 0, ptr unchanged. Repeat with ack in the same cycle -> ack path taken and ptr = 4.
6. Assert rst during VALID with pend = 9'h0F0 -> irq_valid = 0 and pend = 0 after that edge. Ack on the following cycle is ignored.
